// File: rtl/cpu_pkg.sv
// Shared fetch-side types and constants.
// Imported by the fetch stage and its holding register.
package cpu_pkg;

  localparam logic [31:0] NOP_INS = 32'h0000_0000;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory handshake bundle.
// Single outstanding request, in-order responses.
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry {ins, pc} holding register.
// Clear beats load, load beats drain.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic        clear_i,
  input  logic [31:0] ins_i,
  input  logic [31:0] pc_i,
  output logic [31:0] ins_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  logic [31:0] ins_q;
  logic [31:0] pc_q;
  logic        valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ins_q   <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      ins_q   <= ins_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign ins_o   = ins_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register, one outstanding imem request.
// Optional stall counter enabled by defining STALL_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = cpu_pkg::PC_STEP,
  parameter logic [31:0] NOP_INS  = cpu_pkg::NOP_INS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  fetch_stage_if.master imem,
  output logic [31:0]   id_ins,
  output logic [31:0]   id_pc,
`ifdef STALL_CNT_EN
  output logic [31:0]   stall_cycles,
`endif
  output logic          id_valid
);

  import cpu_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d, req_pc_q;
  if_id_t       ifid_q, ifid_d;
  logic         accept, resp;
  logic         hold_valid, hold_load, hold_drain;
  logic [31:0]  hold_ins, hold_pc;

  // A full hold buffer blocks new requests until decode drains it.
  assign imem.imem_req  = ~rst & (state_q == S_REQ) & ~hold_valid;
  assign imem.imem_addr = pc_q;

  assign accept     = imem.imem_req & imem.imem_ready;
  assign resp       = (state_q == S_WAIT) & imem.imem_rvalid;
  assign hold_load  = resp & stall & ~branch_taken;
  assign hold_drain = ~stall & hold_valid & ~branch_taken;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ:
        if (accept)
          state_d = branch_taken ? S_DROP : S_WAIT;
      S_WAIT:
        if (branch_taken)
          state_d = imem.imem_rvalid ? S_REQ : S_DROP;
        else if (imem.imem_rvalid)
          state_d = S_REQ;
      S_DROP:
        if (imem.imem_rvalid)
          state_d = S_REQ;
      default:
        state_d = S_REQ;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (branch_taken)
      pc_d = branch_target;
    else if (accept)
      pc_d = pc_q + PC_STEP;
  end

  always_comb begin
    ifid_d = '{ins: NOP_INS, pc: 32'h0, valid: 1'b0};
    priority case (1'b1)
      branch_taken: ;
      stall:        ifid_d = ifid_q;
      hold_valid:   ifid_d = '{hold_ins, hold_pc, 1'b1};
      resp:         ifid_d = '{imem.imem_rdata, req_pc_q, 1'b1};
      default:      ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      ifid_q   <= '{ins: NOP_INS, pc: 32'h0, valid: 1'b0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      if (accept)
        req_pc_q <= pc_q;
    end
  end

  fetch_hold_buf u_hold (
    .clk     (clk),
    .rst     (rst),
    .load_i  (hold_load),
    .drain_i (hold_drain),
    .clear_i (branch_taken),
    .ins_i   (imem.imem_rdata),
    .pc_i    (req_pc_q),
    .ins_o   (hold_ins),
    .pc_o    (hold_pc),
    .valid_o (hold_valid)
  );

  assign id_ins   = ifid_q.ins;
  assign id_pc    = ifid_q.pc;
  assign id_valid = ifid_q.valid;

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (stall & ifid_q.valid)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: random stall/branch/memory timing
// checked against a stream-level model of expected fetches.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] id_ins, id_pc;
  logic        id_valid;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  fetch_stage_if imem ();

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (imem),
    .id_ins        (id_ins),
    .id_pc         (id_pc),
`ifdef STALL_CNT_EN
    .stall_cycles  (stall_cycles),
`endif
    .id_valid      (id_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          dly;
  } pend_t;

  exp_t        sb[$];
  pend_t       mq[$];
  int          checks = 0;
  int          failures = 0;
  int          delivered = 0;
  int          exp_stall = 0;
  int          lat_max = 0;
  logic [31:0] exp_fetch_pc = RST_PC;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h11;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus; memory model and fetch-stream model advance here.
  task automatic step(input logic s, input logic b,
                      input logic [31:0] t, input logic rdy);
    @(negedge clk);
    stall = s;
    branch_taken = b;
    branch_target = t;
    imem.imem_ready = rdy;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata = 32'hDEAD_BEEF;
    if (mq.size() > 0) begin
      if (mq[0].dly == 0) begin
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata = mem(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        mq[0].dly = mq[0].dly - 1;
      end
    end
    #1;
    if (imem.imem_req) chk("single_outstanding", mq.size(), 0);
    if (imem.imem_req && imem.imem_ready) begin
      chk("imem_addr", imem.imem_addr, exp_fetch_pc);
      mq.push_back('{imem.imem_addr, $urandom_range(lat_max, 0)});
      sb.push_back('{mem(exp_fetch_pc), exp_fetch_pc});
      exp_fetch_pc = exp_fetch_pc + 32'd4;
    end
    if (b) begin
      sb.delete();
      exp_fetch_pc = t;
    end
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    rst = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    imem.imem_ready = 1'b0;
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata = 32'h44;
    mq.delete();
    sb.delete();
    exp_fetch_pc = RST_PC;
    #1;
    chk("rst_req", {31'h0, imem.imem_req}, 32'h0);
    chk("rst_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_ins", id_ins, NOP);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req", {31'h0, imem.imem_req}, 32'h1);
    chk("post_rst_addr", imem.imem_addr, RST_PC);
  endtask

  // Monitor: compares IF/ID after each edge using inputs of that cycle.
  initial begin : monitor
    logic        pv;
    logic [31:0] pins, ppc;
    exp_t        e;
    pv = 1'b0;
    pins = NOP;
    ppc = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        pv = 1'b0;
        pins = NOP;
        ppc = '0;
        exp_stall = 0;
        continue;
      end
      if (stall && pv) exp_stall++;
      if (branch_taken) begin
        chk("flush_valid", {31'h0, id_valid}, 32'h0);
        chk("flush_ins", id_ins, NOP);
      end else if (stall) begin
        chk("hold_valid", {31'h0, id_valid}, {31'h0, pv});
        chk("hold_ins", id_ins, pins);
        chk("hold_pc", id_pc, ppc);
      end else if (id_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got ins %h pc %h expected bubble",
                   id_ins, id_pc);
        end else begin
          e = sb.pop_front();
          chk("id_ins", id_ins, e.ins);
          chk("id_pc", id_pc, e.pc);
          delivered++;
        end
      end else begin
        chk("bubble_ins", id_ins, NOP);
      end
`ifdef STALL_CNT_EN
      chk("stall_cycles", stall_cycles, exp_stall);
`endif
      pv = id_valid;
      pins = id_ins;
      ppc = id_pc;
    end
  end

  initial begin : driver
    int d0;
    imem.imem_ready = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata = '0;
    #1 rst = 1'b1;
    #1;
    chk("reset_req", {31'h0, imem.imem_req}, 32'h0);
    chk("reset_valid", {31'h0, id_valid}, 32'h0);
    chk("reset_ins", id_ins, NOP);
    chk("reset_pc", id_pc, 32'h0);
`ifdef STALL_CNT_EN
    chk("reset_stall_cnt", stall_cycles, 32'h0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    lat_max = 0;
    repeat (4) step(1'b0, 1'b0, '0, 1'b1);
    d0 = delivered;
    repeat (20) step(1'b0, 1'b0, '0, 1'b1);
    chk("throughput", delivered - d0, 10);

    repeat (4) step(1'b1, 1'b0, '0, 1'b1);
    repeat (4) step(1'b0, 1'b0, '0, 1'b1);

    lat_max = 0;
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    lat_max = 3;
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    repeat (8) step(1'b0, 1'b0, '0, 1'b1);

    step(1'b1, 1'b1, 32'h0000_0300, 1'b1);
    repeat (6) step(1'b0, 1'b0, '0, 1'b1);

    lat_max = 0;
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (10) step(1'b0, 1'b0, '0, 1'b1);

    lat_max = 2;
    step(1'b0, 1'b0, '0, 1'b1);
    reset_mid_run();
    repeat (6) step(1'b0, 1'b0, '0, 1'b1);

    d0 = delivered;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(3, 0) == 0) tgt = 32'hFFFF_FFF0;
      lat_max = 2;
      step($urandom_range(3, 0) == 0,
           $urandom_range(19, 0) == 0,
           tgt,
           $urandom_range(9, 0) < 7);
    end
    repeat (8) step(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (delivered - d0 < 200) begin
      failures++;
      $display("FAIL progress: got %0d delivered expected at least 200",
               delivered - d0);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
